// File: rtl/miriscv_data_arbiter.sv
`default_nettype none
// ============================================================================
// miriscv_data_arbiter: two-master arbiter for the miriscv_ram data port,
// routing in-order responses back to the issuing master via an ID FIFO.
// Revision: 1.0
// ============================================================================
module miriscv_data_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ARB_MODE        = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,

  output logic        err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       last_grant_q, last_grant_d;
  logic                       err_q, err_d;

  logic full;
  logic empty;
  logic winner;
  logic sel_valid;
  logic accept;
  logic pop;
  logic head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // winner == 1 selects master 1; only meaningful when some master requests
  always_comb begin
    winner = 1'b0;
    if (ARB_MODE == 1) begin
      winner = ~m0_req_i;
    end else if (m0_req_i && m1_req_i) begin
      winner = ~last_grant_q;
    end else begin
      winner = ~m0_req_i;
    end
  end

  assign sel_valid = rst_n_i & (m0_req_i | m1_req_i) & ~full;
  assign accept    = sel_valid & s_gnt_i;

  assign s_req_o   = sel_valid;
  assign s_we_o    = sel_valid & (winner ? m1_we_i : m0_we_i);
  assign s_be_o    = sel_valid ? (winner ? m1_be_i    : m0_be_i)    : 4'h0;
  assign s_addr_o  = sel_valid ? (winner ? m1_addr_i  : m0_addr_i)  : 32'h0;
  assign s_wdata_o = sel_valid ? (winner ? m1_wdata_i : m0_wdata_i) : 32'h0;

  assign m0_gnt_o  = accept & ~winner;
  assign m1_gnt_o  = accept &  winner;

  // Responses with no outstanding ID are dropped and flagged instead of routed
  assign pop         = rst_n_i & s_rvalid_i & ~empty;
  assign head        = ids_q[rptr_q];
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop &  head;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'h0;
  assign err_o       = err_q;

  always_comb begin
    ids_d        = ids_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | (s_rvalid_i & empty);

    if (accept) begin
      ids_d[wptr_q] = winner;
      wptr_d        = next_ptr(wptr_q);
      last_grant_d  = winner;
    end

    if (pop) begin
      rptr_d = next_ptr(rptr_q);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ids_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      ids_q        <= ids_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_data_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_miriscv_data_arbiter: three arbiter configurations, each on a 1-cycle RAM
// model, with a response scoreboard and directed arbitration checks.
// Revision: 1.0
// ============================================================================
module tb_miriscv_data_arbiter;

  localparam int N_DUT = 3;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n_nxt;
  always #5 clk = ~clk;

  txn_t mq [N_DUT][2][$];
  exp_t sb [N_DUT][$];
  int   gm [N_DUT][$];
  int   gc [N_DUT][$];

  logic        m_req    [N_DUT][2];
  logic        m_we     [N_DUT][2];
  logic [3:0]  m_be     [N_DUT][2];
  logic [31:0] m_addr   [N_DUT][2];
  logic [31:0] m_wdata  [N_DUT][2];
  logic        m_gnt    [N_DUT][2];
  logic        m_rvalid [N_DUT][2];
  logic [31:0] m_rdata  [N_DUT][2];

  logic        s_req    [N_DUT];
  logic        s_we     [N_DUT];
  logic [3:0]  s_be     [N_DUT];
  logic [31:0] s_addr   [N_DUT];
  logic [31:0] s_wdata  [N_DUT];
  logic        s_rvalid [N_DUT];
  logic [31:0] s_rdata  [N_DUT];
  logic        err      [N_DUT];
  logic        spur     [N_DUT];
  logic        spur_nxt [N_DUT];

  logic [31:0] shadow     [N_DUT][64];
  logic        gnt_prev   [N_DUT][2];
  int          rv_cnt     [N_DUT][2];
  logic [31:0] last_rdata [N_DUT][2];
  int          stalls     [N_DUT];

  int cyc;
  int total;
  int bad;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    logic [31:0] mem [64];
    logic        rv_q;
    logic [31:0] rd_q;

    assign s_rvalid[g] = rv_q | spur[g];
    assign s_rdata[g]  = rd_q;

    miriscv_data_arbiter #(
      .MAX_OUTSTANDING ((g == 1) ? 1 : 2),
      .ARB_MODE        ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .m0_req_i    (m_req[g][0]),
      .m0_we_i     (m_we[g][0]),
      .m0_be_i     (m_be[g][0]),
      .m0_addr_i   (m_addr[g][0]),
      .m0_wdata_i  (m_wdata[g][0]),
      .m0_gnt_o    (m_gnt[g][0]),
      .m0_rvalid_o (m_rvalid[g][0]),
      .m0_rdata_o  (m_rdata[g][0]),
      .m1_req_i    (m_req[g][1]),
      .m1_we_i     (m_we[g][1]),
      .m1_be_i     (m_be[g][1]),
      .m1_addr_i   (m_addr[g][1]),
      .m1_wdata_i  (m_wdata[g][1]),
      .m1_gnt_o    (m_gnt[g][1]),
      .m1_rvalid_o (m_rvalid[g][1]),
      .m1_rdata_o  (m_rdata[g][1]),
      .s_req_o     (s_req[g]),
      .s_we_o      (s_we[g]),
      .s_be_o      (s_be[g]),
      .s_addr_o    (s_addr[g]),
      .s_wdata_o   (s_wdata[g]),
      .s_gnt_i     (1'b1),
      .s_rvalid_i  (s_rvalid[g]),
      .s_rdata_i   (s_rdata[g]),
      .err_o       (err[g])
    );

    initial begin
      for (int k = 0; k < 64; k++) mem[k] = (k == 4) ? 32'h0 : 32'hA5A5_0000 + 32'(k);
    end

    // RAM model: always grants, responds one cycle later, returns 0 for writes
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv_q <= 1'b0;
        rd_q <= 32'h0;
      end else begin
        rv_q <= s_req[g];
        rd_q <= 32'h0;
        if (s_req[g]) begin
          if (s_we[g]) begin
            for (int b = 0; b < 4; b++)
              if (s_be[g][b]) mem[s_addr[g][7:2]][8*b +: 8] <= s_wdata[g][8*b +: 8];
          end else begin
            rd_q <= mem[s_addr[g][7:2]];
          end
        end
      end
    end
  end

  function automatic txn_t rd(input logic [31:0] a);
    txn_t t;
    t.we = 1'b0; t.be = 4'hF; t.addr = a; t.wdata = 32'h0;
    return t;
  endfunction

  function automatic txn_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    txn_t t;
    t.we = 1'b1; t.be = be; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic monitor(input int i);
    txn_t        t;
    exp_t        e;
    logic [31:0] d;
    gnt_prev[i][0] = m_gnt[i][0];
    gnt_prev[i][1] = m_gnt[i][1];
    if (!rst_n) begin
      sb[i].delete();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (!m_rvalid[i][m]) chk($sformatf("rdata_idle d%0d m%0d", i, m), m_rdata[i][m], 32'h0);
      if (m_gnt[i][m]) begin
        t = mq[i][m][0];
        chk($sformatf("fwd_addr d%0d m%0d", i, m), s_addr[i], t.addr);
        chk($sformatf("fwd_we d%0d m%0d", i, m), 32'(s_we[i]), 32'(t.we));
        if (t.we) begin
          for (int b = 0; b < 4; b++)
            if (t.be[b]) shadow[i][t.addr[7:2]][8*b +: 8] = t.wdata[8*b +: 8];
          d = 32'h0;
        end else begin
          d = shadow[i][t.addr[7:2]];
        end
        e.m = m; e.data = d; e.cyc = cyc;
        sb[i].push_back(e);
        gm[i].push_back(m);
        gc[i].push_back(cyc);
      end
    end
    if (m_req[i][0] && !s_req[i]) stalls[i]++;
    for (int m = 0; m < 2; m++) begin
      if (m_rvalid[i][m]) begin
        rv_cnt[i][m]++;
        last_rdata[i][m] = m_rdata[i][m];
        total++;
        assert (sb[i].size() > 0) else begin
          bad++;
          $error("FAIL resp_unexpected d%0d m%0d: observed=rvalid expected=none", i, m);
        end
        if (sb[i].size() > 0) begin
          e = sb[i].pop_front();
          chk($sformatf("resp_master d%0d", i), 32'(m), 32'(e.m));
          chk($sformatf("resp_data d%0d m%0d", i, m), m_rdata[i][m], e.data);
          chk($sformatf("resp_latency d%0d m%0d", i, m), 32'(cyc - e.cyc), 32'd1);
        end
      end
    end
  endtask

  task automatic step();
    txn_t t;
    @(negedge clk);
    cyc++;
    rst_n = rst_n_nxt;
    for (int i = 0; i < N_DUT; i++) begin
      spur[i] = spur_nxt[i];
      for (int m = 0; m < 2; m++) begin
        if (gnt_prev[i][m]) void'(mq[i][m].pop_front());
        if (mq[i][m].size() > 0) begin
          t = mq[i][m][0];
          m_req[i][m] = 1'b1; m_we[i][m] = t.we; m_be[i][m] = t.be;
          m_addr[i][m] = t.addr; m_wdata[i][m] = t.wdata;
        end else begin
          m_req[i][m] = 1'b0; m_we[i][m] = 1'b0; m_be[i][m] = 4'h0;
          m_addr[i][m] = 32'h0; m_wdata[i][m] = 32'h0;
        end
      end
    end
    #2;
    for (int i = 0; i < N_DUT; i++) monitor(i);
  endtask

  function automatic logic busy(input int i);
    return (mq[i][0].size() > 0) || (mq[i][1].size() > 0) || (sb[i].size() > 0);
  endfunction

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (busy(i) && n < budget) begin
      step();
      n++;
    end
    total++;
    assert (!busy(i)) else begin
      bad++;
      $error("FAIL idle_timeout d%0d: observed=busy expected=idle within %0d cycles", i, budget);
    end
  endtask

  initial begin
    int rv0;
    int rv1;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; rst_n_nxt = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      spur[i] = 1'b0; spur_nxt[i] = 1'b0; stalls[i] = 0;
      for (int k = 0; k < 64; k++) shadow[i][k] = (k == 4) ? 32'h0 : 32'hA5A5_0000 + 32'(k);
      for (int m = 0; m < 2; m++) begin
        m_req[i][m] = 1'b0; m_we[i][m] = 1'b0; m_be[i][m] = 4'h0;
        m_addr[i][m] = 32'h0; m_wdata[i][m] = 32'h0;
        gnt_prev[i][m] = 1'b0; rv_cnt[i][m] = 0; last_rdata[i][m] = 32'h0;
      end
    end

    // Reset with both masters requesting, then round-robin reads
    mq[0][0].push_back(rd(32'h20)); mq[0][0].push_back(rd(32'h24));
    mq[0][1].push_back(rd(32'h40)); mq[0][1].push_back(rd(32'h44));
    repeat (2) step();
    chk("rst_s_req", 32'(s_req[0]), 32'd0);
    chk("rst_gnt0", 32'(m_gnt[0][0]), 32'd0);
    chk("rst_gnt1", 32'(m_gnt[0][1]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    rst_n_nxt = 1'b1;
    wait_idle(0, 20);
    chk("rr_grants", 32'(gm[0].size()), 32'd4);
    for (int k = 0; k < 4 && k < gm[0].size(); k++)
      chk($sformatf("rr_order %0d", k), 32'(gm[0][k]), 32'(k % 2));
    for (int k = 1; k < 4 && k < gc[0].size(); k++)
      chk($sformatf("rr_rate %0d", k), 32'(gc[0][k] - gc[0][k-1]), 32'd1);

    // m1 partial write then m0 reads it back
    rv0 = rv_cnt[0][0];
    rv1 = rv_cnt[0][1];
    mq[0][1].push_back(wr(32'h10, 32'hDEAD_BEEF, 4'b0011));
    wait_idle(0, 10);
    mq[0][0].push_back(rd(32'h10));
    wait_idle(0, 10);
    chk("wr_rvalid_m1", 32'(rv_cnt[0][1] - rv1), 32'd1);
    chk("rd_rvalid_m0", 32'(rv_cnt[0][0] - rv0), 32'd1);
    chk("rd_after_wr", last_rdata[0][0], 32'h0000_BEEF);

    // Single outstanding slot: back-to-back reads stall every other cycle
    for (int k = 0; k < 4; k++) mq[1][0].push_back(rd(32'(4 * k)));
    wait_idle(1, 30);
    chk("mo1_grants", 32'(gm[1].size()), 32'd4);
    for (int k = 1; k < 4 && k < gc[1].size(); k++)
      chk($sformatf("mo1_spacing %0d", k), 32'(gc[1][k] - gc[1][k-1]), 32'd2);
    chk("mo1_stalls", 32'(stalls[1]), 32'd3);

    // Fixed priority: m0 monopolises until its requests run out
    for (int k = 0; k < 5; k++) mq[2][0].push_back(rd(32'h80 + 32'(4 * k)));
    for (int k = 0; k < 3; k++) mq[2][1].push_back(rd(32'hC0 + 32'(4 * k)));
    wait_idle(2, 30);
    chk("fp_grants", 32'(gm[2].size()), 32'd8);
    for (int k = 0; k < 8 && k < gm[2].size(); k++)
      chk($sformatf("fp_order %0d", k), 32'(gm[2][k]), (k < 5) ? 32'd0 : 32'd1);
    if (gc[2].size() >= 6) chk("fp_handover", 32'(gc[2][5] - gc[2][4]), 32'd1);

    // Spurious response: dropped, sticky error until reset
    chk("err_before", 32'(err[0]), 32'd0);
    spur_nxt[0] = 1'b1;
    step();
    spur_nxt[0] = 1'b0;
    chk("spur_rvalid0", 32'(m_rvalid[0][0]), 32'd0);
    chk("spur_rvalid1", 32'(m_rvalid[0][1]), 32'd0);
    step();
    chk("err_set", 32'(err[0]), 32'd1);
    repeat (3) step();
    chk("err_sticky", 32'(err[0]), 32'd1);
    chk("err_other1", 32'(err[1]), 32'd0);
    chk("err_other2", 32'(err[2]), 32'd0);
    rst_n_nxt = 1'b0;
    step();
    chk("err_cleared", 32'(err[0]), 32'd0);
    rst_n_nxt = 1'b1;
    repeat (2) step();
    chk("err_after_rst", 32'(err[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
